// File: rtl/mcp3202_spi_responder.sv
// SPI slave that emulates an MCP3202 12-bit 2-channel ADC, with digital buses standing in for the analog inputs.
// All SPI pins are resynchronized into clk, and every decision is taken on the synchronized edges.
module mcp3202_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [11:0] ch0_value,
  input  logic [11:0] ch1_value,
  output logic [2:0]  last_cmd,
  output logic        frame_done,
  output logic        frame_abort
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_CMD, S_NULL, S_MSB, S_LSB, S_TAIL
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_prev;
  logic                   cs_prev;
  logic                   sck_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_rise;
  logic                   armed;
  logic [1:0]             cmd_bits;
  logic [1:0]             cmd_cnt;
  logic [3:0]             idx;
  logic [11:0]            data;

  // Single-ended returns the channel; differential is a 13-bit subtract clamped to zero when negative.
  function automatic logic [11:0] convert(input logic sgl, input logic odd,
                                          input logic [11:0] c0, input logic [11:0] c1);
    logic [12:0] diff;
    diff = odd ? ({1'b0, c1} - {1'b0, c0}) : ({1'b0, c0} - {1'b0, c1});
    if (sgl)
      return odd ? c1 : c0;
    else
      return diff[12] ? 12'h000 : diff[11:0];
  endfunction

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_rise  = cs_s & ~cs_prev;

  // CS chain resets low so a select that is already low after reset is never mistaken for a fresh frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_s;
      cs_prev   <= cs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      armed       <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      last_cmd    <= 3'b000;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      cmd_bits    <= 2'b00;
      cmd_cnt     <= 2'd0;
      idx         <= 4'd0;
      data        <= 12'h000;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      if (cs_s) begin
        // Deselect wins over any SCK edge seen in the same clock.
        armed       <= 1'b1;
        state       <= S_IDLE;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        if (cs_rise) begin
          frame_done  <= (state == S_LSB) || (state == S_TAIL);
          frame_abort <= (state == S_CMD) || (state == S_NULL) || (state == S_MSB);
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (armed) state <= S_WAIT_START;
          end
          S_WAIT_START: begin
            if (sck_rise && mosi_s) begin
              state   <= S_CMD;
              cmd_cnt <= 2'd0;
            end
          end
          S_CMD: begin
            if (sck_rise) begin
              cmd_bits <= {cmd_bits[0], mosi_s};
              cmd_cnt  <= cmd_cnt + 2'd1;
              if (cmd_cnt == 2'd2) begin
                data     <= convert(cmd_bits[1], cmd_bits[0], ch0_value, ch1_value);
                last_cmd <= {cmd_bits, mosi_s};
                state    <= S_NULL;
              end
            end
          end
          S_NULL: begin
            if (sck_fall) begin
              spi_miso_oe <= 1'b1;
              spi_miso    <= 1'b0;
              idx         <= 4'd11;
              state       <= S_MSB;
            end
          end
          S_MSB: begin
            if (sck_fall) begin
              spi_miso <= data[idx];
              if (idx == 4'd0) begin
                if (last_cmd[0]) begin
                  state <= S_TAIL;
                end else begin
                  state <= S_LSB;
                  idx   <= 4'd1;
                end
              end else begin
                idx <= idx - 4'd1;
              end
            end
          end
          S_LSB: begin
            if (sck_fall) begin
              spi_miso <= data[idx];
              if (idx == 4'd11) state <= S_TAIL;
              else              idx   <= idx + 4'd1;
            end
          end
          S_TAIL: begin
            if (sck_fall) spi_miso <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcp3202_spi_responder.sv
// Directed bench for mcp3202_spi_responder: an SPI mode-0 master task drives frames and collects MISO.
module tb_mcp3202_spi_responder;
  localparam int SYNC = 2;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic [11:0] ch0_value = 12'h000;
  logic [11:0] ch1_value = 12'h000;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [2:0]  last_cmd;
  logic        frame_done;
  logic        frame_abort;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic [31:0] rx;
  int nd, na;

  mcp3202_spi_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .ch0_value(ch0_value), .ch1_value(ch1_value),
    .last_cmd(last_cmd), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_done)  done_cnt  <= done_cnt + 1;
    if (frame_abort) abort_cnt <= abort_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame: nlead zeros, start bit, cmd {SGL,ODD,MSBF}, then zeros; MISO captured at each SCK rise.
  task automatic spi_frame(input int nlead, input logic [2:0] cmd, input int nsck, input int rst_at,
                           output logic [31:0] rxo, output int ndone, output int nabort);
    int d0, a0;
    logic b;
    d0 = done_cnt;
    a0 = abort_cnt;
    rxo = 32'h0;
    @(negedge clk) spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nsck; i++) begin
      if (i == rst_at) begin
        check_eq("oe_before_rst", {31'b0, spi_miso_oe}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("oe_after_rst", {31'b0, spi_miso_oe}, 32'd0);
        check_eq("cmd_after_rst", {29'b0, last_cmd}, 32'd0);
        rst = 1'b0;
      end
      if (i < nlead)           b = 1'b0;
      else if (i == nlead)     b = 1'b1;
      else if (i <= nlead + 3) b = cmd[nlead + 3 - i];
      else                     b = 1'b0;
      spi_mosi = b;
      repeat (HALF) @(negedge clk);
      rxo = {rxo[30:0], spi_miso};
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    check_eq("oe_after_cs", {31'b0, spi_miso_oe}, 32'd0);
    check_eq("miso_after_cs", {31'b0, spi_miso}, 32'd0);
    repeat (4) @(negedge clk);
    ndone  = done_cnt - d0;
    nabort = abort_cnt - a0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_miso", {31'b0, spi_miso}, 32'd0);
    check_eq("rst_oe", {31'b0, spi_miso_oe}, 32'd0);
    check_eq("rst_last_cmd", {29'b0, last_cmd}, 32'd0);
    check_eq("rst_done", {31'b0, frame_done}, 32'd0);
    check_eq("rst_abort", {31'b0, frame_abort}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // CH0 single-ended, MSB first
    ch0_value = 12'hA5C;
    ch1_value = 12'h3F0;
    spi_frame(0, 3'b101, 17, -1, rx, nd, na);
    check_eq("ch0_rx", {15'b0, rx[16:0]}, 32'h00A5C);
    check_eq("ch0_done", nd, 1);
    check_eq("ch0_abort", na, 0);
    check_eq("ch0_cmd", {29'b0, last_cmd}, 32'd5);

    // CH1 then CH0 again
    spi_frame(0, 3'b111, 17, -1, rx, nd, na);
    check_eq("ch1_rx", {20'b0, rx[11:0]}, 32'h3F0);
    check_eq("ch1_top8", {24'b0, rx[11:4]}, 32'h3F);
    check_eq("ch1_cmd", {29'b0, last_cmd}, 32'd7);
    spi_frame(0, 3'b101, 17, -1, rx, nd, na);
    check_eq("ch0b_rx", {20'b0, rx[11:0]}, 32'hA5C);

    // Differential, clamp and positive result
    ch0_value = 12'h100;
    ch1_value = 12'h180;
    spi_frame(0, 3'b001, 17, -1, rx, nd, na);
    check_eq("diff_clamp", {20'b0, rx[11:0]}, 32'h000);
    check_eq("diff_clamp_cmd", {29'b0, last_cmd}, 32'd1);
    spi_frame(0, 3'b011, 17, -1, rx, nd, na);
    check_eq("diff_pos", {20'b0, rx[11:0]}, 32'h080);

    // MSBF=0: MSB-first, then B1..B11, then tail zeros
    ch0_value = 12'h801;
    spi_frame(0, 3'b100, 31, -1, rx, nd, na);
    check_eq("lsbf_null", {31'b0, rx[26]}, 32'd0);
    check_eq("lsbf_msb", {20'b0, rx[25:14]}, 32'h801);
    check_eq("lsbf_lsb", {21'b0, rx[13:3]}, 32'h001);
    check_eq("lsbf_tail", {29'b0, rx[2:0]}, 32'd0);
    check_eq("lsbf_done", nd, 1);
    check_eq("lsbf_cmd", {29'b0, last_cmd}, 32'd4);

    // Two leading zeros before the start bit
    ch0_value = 12'h5A3;
    spi_frame(2, 3'b101, 19, -1, rx, nd, na);
    check_eq("lead_rx", {20'b0, rx[11:0]}, 32'h5A3);
    check_eq("lead_done", nd, 1);

    // CS raised after 8 SCK cycles
    spi_frame(0, 3'b111, 8, -1, rx, nd, na);
    check_eq("abort_pulse", na, 1);
    check_eq("abort_nodone", nd, 0);

    // Reset in the middle of the MSB phase, then a clean frame
    spi_frame(0, 3'b101, 17, 10, rx, nd, na);
    check_eq("rst_frame_done", nd, 0);
    check_eq("rst_frame_abort", na, 0);
    ch0_value = 12'hC3A;
    spi_frame(0, 3'b101, 17, -1, rx, nd, na);
    check_eq("post_rst_rx", {20'b0, rx[11:0]}, 32'hC3A);
    check_eq("post_rst_done", nd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mcp3202_spi_responder.md
Name: mcp3202_spi_responder

Overview:
- Synthesizable SPI responder that emulates an MCP3202 12-bit, 2-channel ADC on the slave side of the SPI bus.
- Lets the ADC master controller be exercised in loopback on the FPGA, or in simulation, without the physical part.
- Analog inputs are replaced by two 12-bit digital value buses. SCK, CS_N and MOSI are sampled in the system clock domain.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on spi_sck/spi_cs_n/spi_mosi (min 2).

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  synchronous active-high reset
- spi_sck  input  1  SPI clock from master (mode 0,0: idle low)
- spi_cs_n  input  1  chip select, active low
- spi_mosi  input  1  command bits from master
- spi_miso  output  1  data to master; forced 0 when spi_miso_oe=0
- spi_miso_oe  output  1  1 while the responder drives MISO (top level tri-states when 0)
- ch0_value  input  12  emulated CH0 code
- ch1_value  input  12  emulated CH1 code
- last_cmd  output  3  {SGL, ODD, MSBF} of last accepted command
- frame_done  output  1  1-clk pulse: frame completed
- frame_abort  output  1  1-clk pulse: frame cut short

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, last_cmd=3'b000, frame_done=0, frame_abort=0, state=S_IDLE.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops, then one edge-detect flop.
  - sck_rise/sck_fall/cs_rise are single-clk pulses.
  - Reaction latency from a pin edge is SYNC_STAGES+1 clk.
  - Valid only if the SCK half-period is at least SYNC_STAGES+3 clk (the 25-clk master satisfies this).
- cs_rise or synchronized CS_N=1 in any state -> S_IDLE next clk: spi_miso_oe=0, spi_miso=0.
- FSM, with all edges taken on synchronized signals:
  - S_IDLE: CS_N low -> S_WAIT_START.
  - S_WAIT_START: on sck_rise sample MOSI. 0 is ignored (leading zeros are legal); 1 -> S_CMD with cmd count 0.
  - S_CMD:
    - On each sck_rise, shift MOSI into cmd: SGL, then ODD, then MSBF.
    - On the 3rd bit (MSBF), latch the conversion result into the 12-bit data register and update last_cmd. Channel values changing later in the frame have no effect.
    - Go to S_NULL.
  - S_NULL: on sck_fall set spi_miso_oe=1, spi_miso=0 (null bit); -> S_MSB with index 11.
  - S_MSB:
    - On each sck_fall, drive data[index] and decrement.
    - After B0 is driven: MSBF=1 -> S_TAIL; MSBF=0 -> S_LSB with index 1.
  - S_LSB: on each sck_fall drive data[index] from B1 up to B11, then -> S_TAIL.
  - S_TAIL: on sck_fall drive spi_miso=0 and keep oe=1 until CS rises.
- Conversion result, latched on the MSBF sample:
  - SGL=1, ODD=0: ch0_value.
  - SGL=1, ODD=1: ch1_value.
  - SGL=0, ODD=0: ch0-ch1, saturated to 0 if negative (13-bit subtract; clamp on sign bit).
  - SGL=0, ODD=1: ch1-ch0, saturated to 0 if negative.
- frame_done: pulses on cs_rise if B0 of the MSB-first phase has already been driven, whether CS rises in S_MSB after B0, in S_LSB or in S_TAIL.
- frame_abort: pulses on cs_rise if the state is S_CMD, S_NULL, or S_MSB before B0 was driven. No pulse from S_IDLE or S_WAIT_START.
- Simultaneous events: cs_rise beats sck_rise/sck_fall in the same clk; the SCK edge is ignored.
- Reset mid-frame: all outputs return to reset values next clk. The responder waits for CS_N high, then low again, before accepting a start bit.

Test Plan:
- ch0=12'hA5C, master sends 1,1,0,1 (CH0, MSBF) over 17 clocks -> MISO null 0, then bits of A5C MSB-first; frame_done pulse; last_cmd=3'b101.
- ch1=12'h3F0, alternating CH0/CH1 frames from the master controller -> CH1 frame returns 3F0 and the master's 8-bit register reads the top 8 bits 8'h3F.
- Differential: ch0=12'h100, ch1=12'h180, cmd SGL=0 ODD=0 -> 12'h000 (clamped); ODD=1 -> 12'h080.
- MSBF=0, ch0=12'h801 -> B11..B0 of 801 then B1..B11 (0,0,...,0,1), then zeros in S_TAIL; frame_done at CS rise.
- Two leading zeros before the start bit -> command still decoded correctly. CS raised after 8 SCK cycles -> frame_abort pulse, MISO oe=0 within SYNC_STAGES+2 clk.
- rst asserted during S_MSB -> spi_miso_oe=0 next clk; a new frame after CS high/low completes normally with the correct data.
